// File: rtl/prometheus_fx3_pkg.sv
// Shared types and constants for the FX3 slave-FIFO stream scheduler.
package prometheus_fx3_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_IN   = 2'd1,
        GRANT_OUT  = 2'd2,
        TURNAROUND = 2'd3
    } sched_state_t;

    typedef enum logic {
        MODE_IN  = 1'b0,
        MODE_OUT = 1'b1
    } mode_t;

    localparam logic [1:0] DEFAULT_ADDR_IN  = 2'b00;
    localparam logic [1:0] DEFAULT_ADDR_OUT = 2'b11;
    localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/prometheus_fx3_quota_counter.sv
// Per-grant beat counter: latches the quota on load, counts strobes
// (saturating), and flags the beat that exhausts a non-zero quota.
module prometheus_fx3_quota_counter #(
    parameter int unsigned QUOTA_W = 16
) (
    input  logic               clk_100,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic               active,
    input  logic               strobe,
    input  logic [QUOTA_W-1:0] quota,
    output logic               last_beat
);

    localparam logic [QUOTA_W-1:0] ONE = QUOTA_W'(1);

    logic [QUOTA_W-1:0] quota_q;
    logic [QUOTA_W-1:0] count;

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            quota_q <= '0;
            count   <= '0;
        end else if (load) begin
            quota_q <= quota;
            count   <= '0;
        end else if (clear) begin
            count   <= '0;
        end else if (active && strobe && (count != '1)) begin
            count   <= count + ONE;
        end
    end

    // Quota of zero means unlimited, so it never produces a terminal beat.
    assign last_beat = active && strobe && (quota_q != '0) && (count == quota_q - ONE);

endmodule

// File: rtl/prometheus_fx3_stream_scheduler.sv
// Round-robin GPIF bus arbiter between stream-in and stream-out engines.
// Optional grant statistics: define PROMETHEUS_FX3_SCHED_STATS_EN.
module prometheus_fx3_stream_scheduler
    import prometheus_fx3_pkg::*;
#(
    parameter int unsigned QUOTA_W           = 16,
    parameter int unsigned TURNAROUND_CYCLES = 3,
    parameter logic [1:0]  ADDR_IN           = DEFAULT_ADDR_IN,
    parameter logic [1:0]  ADDR_OUT          = DEFAULT_ADDR_OUT
) (
    input  logic               clk_100,
    input  logic               rst_n,
    input  logic               req_stream_in,
    input  logic               req_stream_out,
    input  logic [QUOTA_W-1:0] cfg_quota,
    input  logic               i_we_n_stream_in,
    input  logic               i_rd_n_stream_out,
    input  logic               i_oe_n_stream_out,
    output logic               stream_in_mode_selected,
    output logic               stream_out_mode_selected,
    output logic [1:0]         o_gpif_addr,
    output logic               o_gpif_we_n,
    output logic               o_gpif_rd_n,
    output logic               o_gpif_oe_n,
    output logic               o_busy,
    output logic [15:0]        o_grant_cnt_in,
    output logic [15:0]        o_grant_cnt_out
);

    localparam int unsigned TA_W = (TURNAROUND_CYCLES < 2) ? 1 : $clog2(TURNAROUND_CYCLES);
    localparam logic [TA_W-1:0] TA_LAST = TA_W'(TURNAROUND_CYCLES - 1);

    sched_state_t    state;
    sched_state_t    state_next;
    mode_t           rr_last;
    logic [1:0]      addr_q;
    logic [TA_W-1:0] ta_cnt;
    logic            grant_in_entry;
    logic            grant_out_entry;
    logic            leave_grant;
    logic            in_grant;
    logic            strobe_sel;
    logic            last_beat;

    always_ff @(posedge clk_100) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next      = state;
        grant_in_entry  = 1'b0;
        grant_out_entry = 1'b0;
        leave_grant     = 1'b0;
        case (state)
            IDLE: begin
                if (req_stream_in && (!req_stream_out || rr_last == MODE_OUT)) begin
                    state_next     = GRANT_IN;
                    grant_in_entry = 1'b1;
                end else if (req_stream_out) begin
                    state_next      = GRANT_OUT;
                    grant_out_entry = 1'b1;
                end
            end
            GRANT_IN: begin
                if (!req_stream_in || last_beat) begin
                    state_next  = TURNAROUND;
                    leave_grant = 1'b1;
                end
            end
            GRANT_OUT: begin
                if (!req_stream_out || last_beat) begin
                    state_next  = TURNAROUND;
                    leave_grant = 1'b1;
                end
            end
            TURNAROUND: begin
                if (ta_cnt == TA_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            rr_last <= MODE_OUT;
            addr_q  <= ADDR_IN;
            ta_cnt  <= '0;
        end else begin
            if (grant_in_entry)  addr_q <= ADDR_IN;
            if (grant_out_entry) addr_q <= ADDR_OUT;
            if (leave_grant)     rr_last <= (state == GRANT_IN) ? MODE_IN : MODE_OUT;
            ta_cnt <= (state == TURNAROUND) ? ta_cnt + TA_W'(1) : '0;
        end
    end

    assign in_grant   = (state == GRANT_IN) || (state == GRANT_OUT);
    assign strobe_sel = ((state == GRANT_IN)  && !i_we_n_stream_in) ||
                        ((state == GRANT_OUT) && !i_rd_n_stream_out);

    prometheus_fx3_quota_counter #(
        .QUOTA_W (QUOTA_W)
    ) u_quota (
        .clk_100   (clk_100),
        .rst_n     (rst_n),
        .load      (grant_in_entry || grant_out_entry),
        .clear     (leave_grant),
        .active    (in_grant),
        .strobe    (strobe_sel),
        .quota     (cfg_quota),
        .last_beat (last_beat)
    );

    // Strobes are also blocked while reset is asserted so no beat leaks mid-reset.
    always_comb begin
        stream_in_mode_selected  = (state == GRANT_IN);
        stream_out_mode_selected = (state == GRANT_OUT);
        o_gpif_addr              = addr_q;
        o_busy                   = (state != IDLE);
        o_gpif_we_n              = 1'b1;
        o_gpif_rd_n              = 1'b1;
        o_gpif_oe_n              = 1'b1;
        if (rst_n && state == GRANT_IN) begin
            o_gpif_we_n = i_we_n_stream_in;
        end else if (rst_n && state == GRANT_OUT) begin
            o_gpif_rd_n = i_rd_n_stream_out;
            o_gpif_oe_n = i_oe_n_stream_out;
        end
    end

`ifdef PROMETHEUS_FX3_SCHED_STATS_EN
    logic [STATS_W-1:0] grant_cnt_in_q;
    logic [STATS_W-1:0] grant_cnt_out_q;

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            grant_cnt_in_q  <= '0;
            grant_cnt_out_q <= '0;
        end else begin
            if (grant_in_entry && grant_cnt_in_q != '1)
                grant_cnt_in_q <= grant_cnt_in_q + STATS_W'(1);
            if (grant_out_entry && grant_cnt_out_q != '1)
                grant_cnt_out_q <= grant_cnt_out_q + STATS_W'(1);
        end
    end

    assign o_grant_cnt_in  = grant_cnt_in_q;
    assign o_grant_cnt_out = grant_cnt_out_q;
`else
    assign o_grant_cnt_in  = '0;
    assign o_grant_cnt_out = '0;
`endif

endmodule

// File: tb/tb_prometheus_fx3_stream_scheduler.sv
// Directed self-checking bench for prometheus_fx3_stream_scheduler.
module tb_prometheus_fx3_stream_scheduler;

    logic        clk_100 = 1'b0;
    logic        rst_n;
    logic        req_stream_in, req_stream_out;
    logic [15:0] cfg_quota;
    logic        i_we_n_stream_in, i_rd_n_stream_out, i_oe_n_stream_out;
    logic        stream_in_mode_selected, stream_out_mode_selected;
    logic [1:0]  o_gpif_addr;
    logic        o_gpif_we_n, o_gpif_rd_n, o_gpif_oe_n, o_busy;
    logic [15:0] o_grant_cnt_in, o_grant_cnt_out;

`ifdef PROMETHEUS_FX3_SCHED_STATS_EN
    localparam int EXP_STATS_IN  = 3;
    localparam int EXP_STATS_OUT = 2;
`else
    localparam int EXP_STATS_IN  = 0;
    localparam int EXP_STATS_OUT = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int g_mode  [8];
    int g_beats [8];
    int g_gap   [8];
    int n_grants, bad_grant, idle_leak;
    logic mon_ok;

    prometheus_fx3_stream_scheduler dut (
        .clk_100                  (clk_100),
        .rst_n                    (rst_n),
        .req_stream_in            (req_stream_in),
        .req_stream_out           (req_stream_out),
        .cfg_quota                (cfg_quota),
        .i_we_n_stream_in         (i_we_n_stream_in),
        .i_rd_n_stream_out        (i_rd_n_stream_out),
        .i_oe_n_stream_out        (i_oe_n_stream_out),
        .stream_in_mode_selected  (stream_in_mode_selected),
        .stream_out_mode_selected (stream_out_mode_selected),
        .o_gpif_addr              (o_gpif_addr),
        .o_gpif_we_n              (o_gpif_we_n),
        .o_gpif_rd_n              (o_gpif_rd_n),
        .o_gpif_oe_n              (o_gpif_oe_n),
        .o_busy                   (o_busy),
        .o_grant_cnt_in           (o_grant_cnt_in),
        .o_grant_cnt_out          (o_grant_cnt_out)
    );

    always #5 clk_100 = ~clk_100;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100);
        #2;
    endtask

    task automatic apply_reset();
        rst_n             = 1'b0;
        req_stream_in     = 1'b0;
        req_stream_out    = 1'b0;
        cfg_quota         = '0;
        i_we_n_stream_in  = 1'b1;
        i_rd_n_stream_out = 1'b1;
        i_oe_n_stream_out = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Records grant order, pin beats per grant and busy gap cycles after each grant.
    task automatic run_monitor(input int want, input int change_at, input logic [15:0] new_quota);
        int cur;
        int prev;
        prev      = 0;
        n_grants  = 0;
        bad_grant = 0;
        idle_leak = 0;
        mon_ok    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            g_mode[k] = 0; g_beats[k] = 0; g_gap[k] = 0;
        end
        for (int i = 1; i <= 150; i++) begin
            tick();
            cur = stream_in_mode_selected ? 1 : (stream_out_mode_selected ? 2 : 0);
            if (cur != 0) begin
                if (cur != prev && n_grants < 7) begin
                    n_grants++;
                    g_mode[n_grants] = cur;
                end
                if (cur == 1) begin
                    if (!o_gpif_we_n) g_beats[n_grants]++;
                    if (!o_gpif_rd_n || !o_gpif_oe_n || o_gpif_addr != 2'b00) bad_grant++;
                end else begin
                    if (!o_gpif_rd_n) g_beats[n_grants]++;
                    if (!o_gpif_we_n || o_gpif_addr != 2'b11) bad_grant++;
                end
            end else begin
                if (o_busy) g_gap[n_grants]++;
                if (!o_gpif_we_n || !o_gpif_rd_n || !o_gpif_oe_n) idle_leak++;
                if (n_grants == want) begin
                    mon_ok = 1'b1;
                    break;
                end
            end
            if (i == change_at) cfg_quota = new_quota;
            prev = cur;
        end
        check_eq("monitor_done", {31'd0, mon_ok}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic held;

        // Reset state
        apply_reset();
        check_eq("rst_mode_in",  {31'd0, stream_in_mode_selected},  32'd0);
        check_eq("rst_mode_out", {31'd0, stream_out_mode_selected}, 32'd0);
        check_eq("rst_addr",     {30'd0, o_gpif_addr}, 32'd0);
        check_eq("rst_strobes",  {29'd0, o_gpif_we_n, o_gpif_rd_n, o_gpif_oe_n}, 32'd7);
        check_eq("rst_busy",     {31'd0, o_busy}, 32'd0);
        check_eq("rst_stats",    {o_grant_cnt_in, o_grant_cnt_out}, 32'd0);

        // Single requester, unlimited quota, then request drop
        req_stream_in     = 1'b1;
        i_rd_n_stream_out = 1'b0;
        i_oe_n_stream_out = 1'b0;
        #1;
        check_eq("t1_latency", {31'd0, stream_in_mode_selected}, 32'd0);
        tick();
        check_eq("t1_mode_in",  {31'd0, stream_in_mode_selected},  32'd1);
        check_eq("t1_mode_out", {31'd0, stream_out_mode_selected}, 32'd0);
        check_eq("t1_addr",     {30'd0, o_gpif_addr}, 32'd0);
        check_eq("t1_busy",     {31'd0, o_busy}, 32'd1);
        check_eq("t1_rd_oe_gated", {30'd0, o_gpif_rd_n, o_gpif_oe_n}, 32'd3);
        i_we_n_stream_in = 1'b0; #1;
        check_eq("t1_we_pass_lo", {31'd0, o_gpif_we_n}, 32'd0);
        i_we_n_stream_in = 1'b1; #1;
        check_eq("t1_we_pass_hi", {31'd0, o_gpif_we_n}, 32'd1);
        i_we_n_stream_in = 1'b0;
        held = 1'b1;
        repeat (30) begin
            tick();
            held = held & stream_in_mode_selected & ~o_gpif_we_n;
        end
        check_eq("t1_hold", {31'd0, held}, 32'd1);
        req_stream_in = 1'b0; #1;
        check_eq("t1_drop_beat", {31'd0, o_gpif_we_n}, 32'd0);
        tick();
        check_eq("t1_ta1", {29'd0, stream_in_mode_selected, o_busy, o_gpif_we_n}, 32'd3);
        tick();
        check_eq("t1_ta2", {31'd0, o_busy}, 32'd1);
        tick();
        check_eq("t1_ta3", {31'd0, o_busy}, 32'd1);
        tick();
        check_eq("t1_idle", {31'd0, o_busy}, 32'd0);

        // Both requesting, quota 4, engines strobing every cycle
        apply_reset();
        cfg_quota         = 16'd4;
        i_we_n_stream_in  = 1'b0;
        i_rd_n_stream_out = 1'b0;
        i_oe_n_stream_out = 1'b0;
        req_stream_in     = 1'b1;
        req_stream_out    = 1'b1;
        run_monitor(5, -1, 16'd0);
        for (int k = 1; k <= 5; k++) begin
            check_eq($sformatf("t2_mode%0d", k), g_mode[k], (k % 2 == 1) ? 32'd1 : 32'd2);
            check_eq($sformatf("t2_beats%0d", k), g_beats[k], 32'd4);
        end
        for (int k = 1; k <= 4; k++)
            check_eq($sformatf("t2_gap%0d", k), g_gap[k], 32'd3);
        check_eq("t2_cross_gating", bad_grant, 32'd0);
        check_eq("t2_idle_strobes", idle_leak, 32'd0);
        check_eq("t2_stats_in",  {16'd0, o_grant_cnt_in},  EXP_STATS_IN);
        check_eq("t2_stats_out", {16'd0, o_grant_cnt_out}, EXP_STATS_OUT);

        // Quota changed 4 -> 2 mid-grant
        apply_reset();
        cfg_quota         = 16'd4;
        i_we_n_stream_in  = 1'b0;
        i_rd_n_stream_out = 1'b0;
        i_oe_n_stream_out = 1'b0;
        req_stream_in     = 1'b1;
        req_stream_out    = 1'b1;
        run_monitor(2, 2, 16'd2);
        check_eq("t4_mode1",  g_mode[1],  32'd1);
        check_eq("t4_beats1", g_beats[1], 32'd4);
        check_eq("t4_mode2",  g_mode[2],  32'd2);
        check_eq("t4_beats2", g_beats[2], 32'd2);

        // Quota of one, single requester re-granted
        apply_reset();
        cfg_quota        = 16'd1;
        i_we_n_stream_in = 1'b0;
        req_stream_in    = 1'b1;
        run_monitor(2, -1, 16'd0);
        check_eq("tq1_mode2",  g_mode[2],  32'd1);
        check_eq("tq1_beats1", g_beats[1], 32'd1);
        check_eq("tq1_beats2", g_beats[2], 32'd1);
        check_eq("tq1_gap1",   g_gap[1],   32'd3);

        // Reset pulse during GRANT_OUT at beat 2
        apply_reset();
        i_we_n_stream_in  = 1'b0;
        i_rd_n_stream_out = 1'b0;
        i_oe_n_stream_out = 1'b0;
        req_stream_out    = 1'b1;
        tick();
        check_eq("t5_grant_out", {29'd0, stream_out_mode_selected, o_gpif_addr}, 32'd7);
        check_eq("t5_rd_beat1", {31'd0, o_gpif_rd_n}, 32'd0);
        tick();
        check_eq("t5_rd_beat2", {31'd0, o_gpif_rd_n}, 32'd0);
        rst_n         = 1'b0;
        req_stream_in = 1'b1;
        #1;
        check_eq("t5_rst_strobes", {29'd0, o_gpif_we_n, o_gpif_rd_n, o_gpif_oe_n}, 32'd7);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("t5_modes", {30'd0, stream_in_mode_selected, stream_out_mode_selected}, 32'd0);
        check_eq("t5_addr",  {30'd0, o_gpif_addr}, 32'd0);
        check_eq("t5_strobes", {29'd0, o_gpif_we_n, o_gpif_rd_n, o_gpif_oe_n}, 32'd7);
        check_eq("t5_busy",  {31'd0, o_busy}, 32'd0);
        tick();
        check_eq("t5_tie_in", {30'd0, stream_in_mode_selected, stream_out_mode_selected}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prometheus_fx3_stream_scheduler.md
Name: prometheus_fx3_stream_scheduler

Overview:
Time-shares the FX3 slave-FIFO GPIF bus between the stream-in (FPGA->host) and stream-out (host->FPGA) engines. It grants the bus to one engine at a time, round-robin with a per-grant beat quota. It drives each engine's mode-select, the socket address and the gated strobes to the pins. Between grants it inserts a bus turnaround. It sits between the mode engines and the GPIF pad logic, clocked by clk_100.

Parameters:
QUOTA_W, 16, width of beat quota/counter
TURNAROUND_CYCLES, 3, idle cycles between grants (min 1)
ADDR_IN, 2'b00, GPIF socket address for stream-in
ADDR_OUT, 2'b11, GPIF socket address for stream-out

Ports:
clk_100  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
req_stream_in  in  1  stream-in engine wants bus (level)
req_stream_out  in  1  stream-out engine wants bus (level)
cfg_quota  in  QUOTA_W  beats per grant; 0 = unlimited
i_we_n_stream_in  in  1  write strobe from stream-in engine (active-low)
i_rd_n_stream_out  in  1  read strobe from stream-out engine (active-low)
i_oe_n_stream_out  in  1  output-enable from stream-out engine (active-low)
stream_in_mode_selected  out  1  enables stream-in engine
stream_out_mode_selected  out  1  enables stream-out engine
o_gpif_addr  out  2  socket address to pins
o_gpif_we_n  out  1  gated write strobe
o_gpif_rd_n  out  1  gated read strobe
o_gpif_oe_n  out  1  gated output enable
o_busy  out  1  state != IDLE
o_grant_cnt_in  out  16  stats (see Optional Feature)
o_grant_cnt_out  out  16  stats

Behaviour:
- Clock and reset: single clock clk_100; rst_n is synchronous and active-low.
- Reset values:
  - state = IDLE, mode selects 0, o_gpif_addr = ADDR_IN, all strobes 1, o_busy 0.
  - beat counter 0, rr_last = OUT, so stream-in wins the first tie.
- States: IDLE, GRANT_IN, GRANT_OUT, TURNAROUND.
- IDLE:
  - Both requests high: grant the engine opposite to rr_last.
  - One request high: grant that engine.
  - Neither: stay in IDLE.
  - On granting, address register loads the winner's address in the same edge as the state change.
- Mode-select latency: mode select asserts on the cycle after the request is sampled (1-cycle latency).
- GRANT_x:
  - Mode select x = 1; the other mode select = 0.
  - Strobes pass through combinationally from engine x; the other engine's strobes are forced to 1.
  - Beat counter increments on each cycle the engine-x strobe (we_n or rd_n) is 0.
- Leaving GRANT_x (go to TURNAROUND) when:
  - req_x = 0, or
  - cfg_quota != 0 and a strobe occurs while counter == cfg_quota-1. That beat is passed; from the next cycle all strobes are forced to 1.
  - Same transition: rr_last <= x, counter cleared.
- TURNAROUND:
  - Mode selects 0, strobes 1, address held.
  - Counts TURNAROUND_CYCLES, then goes to IDLE.
- cfg_quota is sampled on entry to a GRANT state; changes mid-grant take effect at the next grant.
- Request drop mid-burst: the grant ends next edge. The engine sees its mode select low and clears its own data counter. Beats in flight are not replayed.
- Counter saturates at all-ones when quota = 0 (no wrap).
- Reset asserted mid-grant: next edge returns to reset values; strobes are 1 that cycle.

Optional Feature:
PROMETHEUS_FX3_SCHED_STATS_EN
- Defined: o_grant_cnt_in/out are 16-bit counters incremented on each entry to GRANT_IN/GRANT_OUT. They saturate at 16'hFFFF and clear on reset.
- Undefined: the ports exist and are tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package prometheus_fx3_pkg holds:
  - state enum (IDLE=0, GRANT_IN=1, GRANT_OUT=2, TURNAROUND=3)
  - mode id constants (MODE_IN, MODE_OUT)
  - default socket addresses
- One sub-module, prometheus_fx3_quota_counter: load, strobe-count and terminal-beat flag, with saturation.

Test Plan:
- Only req_stream_in=1, cfg_quota=0: GRANT_IN one cycle after request; addr=00; we_n passes through; holds indefinitely; req drop -> 3 turnaround cycles -> IDLE.
- Both req, cfg_quota=4, engines strobing every cycle:
  - grants alternate IN, OUT, IN;
  - exactly 4 strobes reach the pins per grant;
  - 3 idle cycles with all strobes 1 between grants.
- Stream-out engine strobes while stream-in is granted: o_gpif_rd_n/oe_n stay 1 throughout.
- cfg_quota changed 4->2 mid-grant: current grant passes 4 beats; next grant passes 2.
- rst_n low for 1 cycle during GRANT_OUT at beat 2: next cycle all outputs at reset values; the next tie is granted to IN.
- With STATS_EN, 3 in-grants and 2 out-grants: o_grant_cnt_in=3, o_grant_cnt_out=2. Without STATS_EN: both read 0.
